// File: rtl/axis_pkg.sv
// Shared definitions for the AXI4-Stream blocks: frame FSM states and the fill
// values driven on sideband fields that a block instance does not propagate.
package axis_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  localparam logic KEEP_FILL = 1'b1;
  localparam logic ID_FILL   = 1'b0;
  localparam logic DEST_FILL = 1'b0;
  localparam logic USER_FILL = 1'b0;

endpackage

// File: rtl/axis_skid_reg.sv
// Two-entry registered stream stage: an output register plus a temp register
// that catches the one beat in flight when downstream stalls.
module axis_skid_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready
);

  logic [WIDTH-1:0] out_data_reg;
  logic             out_valid_reg;
  logic             out_valid_next;
  logic [WIDTH-1:0] temp_data_reg;
  logic             temp_valid_reg;
  logic             temp_valid_next;
  logic             ready_reg;
  logic             accept;
  logic             load_out_from_in;
  logic             load_out_from_temp;
  logic             load_temp;

  assign accept  = s_valid & ready_reg;
  assign s_ready = ready_reg;
  assign m_data  = out_data_reg;
  assign m_valid = out_valid_reg;

  always_comb begin
    out_valid_next     = out_valid_reg;
    temp_valid_next    = temp_valid_reg;
    load_out_from_in   = 1'b0;
    load_out_from_temp = 1'b0;
    load_temp          = 1'b0;
    if (m_ready || !out_valid_reg) begin
      if (temp_valid_reg) begin
        // Temp is older than anything upstream could offer, so it drains first.
        out_valid_next     = 1'b1;
        temp_valid_next    = 1'b0;
        load_out_from_temp = 1'b1;
      end else begin
        out_valid_next   = accept;
        load_out_from_in = accept;
      end
    end else if (accept) begin
      temp_valid_next = 1'b1;
      load_temp       = 1'b1;
    end
  end

  // Ready is a pure register: upstream never sees a path from m_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_reg   <= '0;
      out_valid_reg  <= 1'b0;
      temp_data_reg  <= '0;
      temp_valid_reg <= 1'b0;
      ready_reg      <= 1'b0;
    end else begin
      out_valid_reg  <= out_valid_next;
      temp_valid_reg <= temp_valid_next;
      ready_reg      <= ~temp_valid_next;
      if (load_out_from_in) begin
        out_data_reg <= s_data;
      end else if (load_out_from_temp) begin
        out_data_reg <= temp_data_reg;
      end
      if (load_temp) begin
        temp_data_reg <= s_data;
      end
    end
  end

endmodule

// File: rtl/axis_mux2_frame.sv
// Two-port AXI4-Stream frame mux: the port is chosen at frame start from
// enable/select and held until the frame's tlast beat has been accepted.
module axis_mux2_frame
  import axis_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int KEEP_ENABLE = (DATA_WIDTH > 8) ? 1 : 0,
  parameter int KEEP_WIDTH  = DATA_WIDTH / 8,
  parameter int ID_ENABLE   = 0,
  parameter int ID_WIDTH    = 8,
  parameter int DEST_ENABLE = 0,
  parameter int DEST_WIDTH  = 8,
  parameter int USER_ENABLE = 1,
  parameter int USER_WIDTH  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic [DATA_WIDTH-1:0] s00_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s00_axis_tkeep,
  input  logic [ID_WIDTH-1:0]   s00_axis_tid,
  input  logic [DEST_WIDTH-1:0] s00_axis_tdest,
  input  logic [USER_WIDTH-1:0] s00_axis_tuser,
  input  logic                  s00_axis_tvalid,
  output logic                  s00_axis_tready,
  input  logic                  s00_axis_tlast,

  input  logic [DATA_WIDTH-1:0] s01_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s01_axis_tkeep,
  input  logic [ID_WIDTH-1:0]   s01_axis_tid,
  input  logic [DEST_WIDTH-1:0] s01_axis_tdest,
  input  logic [USER_WIDTH-1:0] s01_axis_tuser,
  input  logic                  s01_axis_tvalid,
  output logic                  s01_axis_tready,
  input  logic                  s01_axis_tlast,

  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic [ID_WIDTH-1:0]   m_axis_tid,
  output logic [DEST_WIDTH-1:0] m_axis_tdest,
  output logic [USER_WIDTH-1:0] m_axis_tuser,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,

  input  logic                  enable,
  input  logic                  select
);

  localparam int PAYLOAD_W = DATA_WIDTH + KEEP_WIDTH + ID_WIDTH + DEST_WIDTH + USER_WIDTH + 1;

  state_t                state_reg;
  logic                  sel_reg;

  logic                  grant_valid;
  logic                  grant_sel;
  logic [1:0]            port_valid;
  logic [1:0]            port_ready;
  logic                  in_valid;
  logic                  in_ready;
  logic                  accept;

  logic [DATA_WIDTH-1:0] mux_data;
  logic [KEEP_WIDTH-1:0] mux_keep;
  logic [ID_WIDTH-1:0]   mux_id;
  logic [DEST_WIDTH-1:0] mux_dest;
  logic [USER_WIDTH-1:0] mux_user;
  logic                  mux_last;

  logic [KEEP_WIDTH-1:0] gated_keep;
  logic [ID_WIDTH-1:0]   gated_id;
  logic [DEST_WIDTH-1:0] gated_dest;
  logic [USER_WIDTH-1:0] gated_user;

  logic [PAYLOAD_W-1:0]  in_payload;
  logic [PAYLOAD_W-1:0]  out_payload;

  // Between frames the grant follows select live; inside a frame it is frozen.
  always_comb begin
    grant_valid = 1'b0;
    grant_sel   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        grant_valid = enable;
        grant_sel   = select;
      end
      ST_ACTIVE: begin
        grant_valid = 1'b1;
        grant_sel   = sel_reg;
      end
      default: begin
        grant_valid = 1'b0;
        grant_sel   = 1'b0;
      end
    endcase
  end

  assign port_valid = {s01_axis_tvalid, s00_axis_tvalid};

  for (genvar gi = 0; gi < 2; gi++) begin : g_port_ready
    assign port_ready[gi] = grant_valid && (grant_sel == 1'(gi)) && in_ready;
  end

  assign s00_axis_tready = port_ready[0];
  assign s01_axis_tready = port_ready[1];

  assign in_valid = grant_valid && port_valid[grant_sel];
  assign accept   = in_valid && in_ready;

  always_comb begin
    mux_data = s00_axis_tdata;
    mux_keep = s00_axis_tkeep;
    mux_id   = s00_axis_tid;
    mux_dest = s00_axis_tdest;
    mux_user = s00_axis_tuser;
    mux_last = s00_axis_tlast;
    if (grant_sel) begin
      mux_data = s01_axis_tdata;
      mux_keep = s01_axis_tkeep;
      mux_id   = s01_axis_tid;
      mux_dest = s01_axis_tdest;
      mux_user = s01_axis_tuser;
      mux_last = s01_axis_tlast;
    end
  end

  // Disabled sideband fields are replaced before storage so the skid stage
  // only ever holds what downstream should see.
  assign gated_keep = (KEEP_ENABLE != 0) ? mux_keep : {KEEP_WIDTH{KEEP_FILL}};
  assign gated_id   = (ID_ENABLE   != 0) ? mux_id   : {ID_WIDTH{ID_FILL}};
  assign gated_dest = (DEST_ENABLE != 0) ? mux_dest : {DEST_WIDTH{DEST_FILL}};
  assign gated_user = (USER_ENABLE != 0) ? mux_user : {USER_WIDTH{USER_FILL}};

  assign in_payload = {mux_data, gated_keep, gated_id, gated_dest, gated_user, mux_last};

  axis_skid_reg #(
    .WIDTH (PAYLOAD_W)
  ) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_data  (in_payload),
    .s_valid (in_valid),
    .s_ready (in_ready),
    .m_data  (out_payload),
    .m_valid (m_axis_tvalid),
    .m_ready (m_axis_tready)
  );

  assign {m_axis_tdata, m_axis_tkeep, m_axis_tid, m_axis_tdest, m_axis_tuser, m_axis_tlast} = out_payload;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      sel_reg   <= 1'b0;
    end else if (accept) begin
      case (state_reg)
        ST_IDLE: begin
          sel_reg   <= select;
          state_reg <= mux_last ? ST_IDLE : ST_ACTIVE;
        end
        ST_ACTIVE: begin
          if (mux_last) begin
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_mux2_frame.sv
// Directed bench for axis_mux2_frame: per-port beat queues feed the DUT and a
// frame-level reference model checks handshakes and output beats every cycle.
module tb_axis_mux2_frame;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        user;
    logic        last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;

  logic [31:0] s00_axis_tdata, s01_axis_tdata;
  logic [3:0]  s00_axis_tkeep, s01_axis_tkeep;
  logic [7:0]  s00_axis_tid, s01_axis_tid;
  logic [7:0]  s00_axis_tdest, s01_axis_tdest;
  logic [0:0]  s00_axis_tuser, s01_axis_tuser;
  logic        s00_axis_tvalid, s01_axis_tvalid;
  logic        s00_axis_tready, s01_axis_tready;
  logic        s00_axis_tlast, s01_axis_tlast;

  logic [31:0] m_axis_tdata;
  logic [3:0]  m_axis_tkeep;
  logic [7:0]  m_axis_tid;
  logic [7:0]  m_axis_tdest;
  logic [0:0]  m_axis_tuser;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b0;
  logic        m_axis_tlast;

  logic        enable = 1'b0;
  logic        select = 1'b0;

  beat_t       q0[$];
  beat_t       q1[$];
  beat_t       exp_q[$];
  logic [31:0] log_data[$];
  logic        log_last[$];
  int          log_cyc[$];

  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          acc0 = 0;
  int          acc1 = 0;
  bit          fire0 = 1'b0;
  bit          fire1 = 1'b0;

  always #5 clk = ~clk;

  axis_mux2_frame dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .s00_axis_tdata  (s00_axis_tdata),
    .s00_axis_tkeep  (s00_axis_tkeep),
    .s00_axis_tid    (s00_axis_tid),
    .s00_axis_tdest  (s00_axis_tdest),
    .s00_axis_tuser  (s00_axis_tuser),
    .s00_axis_tvalid (s00_axis_tvalid),
    .s00_axis_tready (s00_axis_tready),
    .s00_axis_tlast  (s00_axis_tlast),
    .s01_axis_tdata  (s01_axis_tdata),
    .s01_axis_tkeep  (s01_axis_tkeep),
    .s01_axis_tid    (s01_axis_tid),
    .s01_axis_tdest  (s01_axis_tdest),
    .s01_axis_tuser  (s01_axis_tuser),
    .s01_axis_tvalid (s01_axis_tvalid),
    .s01_axis_tready (s01_axis_tready),
    .s01_axis_tlast  (s01_axis_tlast),
    .m_axis_tdata    (m_axis_tdata),
    .m_axis_tkeep    (m_axis_tkeep),
    .m_axis_tid      (m_axis_tid),
    .m_axis_tdest    (m_axis_tdest),
    .m_axis_tuser    (m_axis_tuser),
    .m_axis_tvalid   (m_axis_tvalid),
    .m_axis_tready   (m_axis_tready),
    .m_axis_tlast    (m_axis_tlast),
    .enable          (enable),
    .select          (select)
  );

  function automatic beat_t mk(input logic [31:0] d, input logic [3:0] k, input logic u, input logic l);
    beat_t b;
    b.data = d;
    b.keep = k;
    b.user = u;
    b.last = l;
    return b;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input int port, input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      beat_t b;
      b = mk(base + 32'(i), (i == n - 1) ? 4'h3 : 4'hF, 1'(i % 2), i == n - 1);
      if (port == 0) q0.push_back(b);
      else q1.push_back(b);
    end
  endtask

  task automatic wait_log(input int target, input int budget);
    int k;
    k = 0;
    while (log_data.size() < target && k < budget) begin
      step(1);
      k++;
    end
    tests++;
    if (log_data.size() < target) begin
      fails++;
      $display("[TB] FAIL wait_log: got %0d beats, expected %0d within %0d clks", log_data.size(), target, budget);
    end
  endtask

  task automatic wait_accept(input int port, input int target, input int budget);
    int k;
    k = 0;
    while (((port == 0) ? acc0 : acc1) < target && k < budget) begin
      step(1);
      k++;
    end
    tests++;
    if (((port == 0) ? acc0 : acc1) < target) begin
      fails++;
      $display("[TB] FAIL wait_accept: port %0d got %0d beats, expected %0d", port, (port == 0) ? acc0 : acc1, target);
    end
  endtask

  // Sources: hold the head beat of each queue until it is handshaked.
  initial begin
    s00_axis_tid = 8'hA5;  s01_axis_tid = 8'h5A;
    s00_axis_tdest = 8'h3C; s01_axis_tdest = 8'hC3;
    s00_axis_tvalid = 1'b0; s01_axis_tvalid = 1'b0;
    s00_axis_tdata = '0; s00_axis_tkeep = '0; s00_axis_tuser = '0; s00_axis_tlast = 1'b0;
    s01_axis_tdata = '0; s01_axis_tkeep = '0; s01_axis_tuser = '0; s01_axis_tlast = 1'b0;
    forever begin
      @(negedge clk);
      fire0 = s00_axis_tvalid && s00_axis_tready;
      fire1 = s01_axis_tvalid && s01_axis_tready;
      @(posedge clk);
      #2;
      if (fire0 && q0.size() > 0) begin void'(q0.pop_front()); acc0++; end
      if (fire1 && q1.size() > 0) begin void'(q1.pop_front()); acc1++; end
      s00_axis_tvalid = q0.size() > 0;
      if (q0.size() > 0) {s00_axis_tdata, s00_axis_tkeep, s00_axis_tuser, s00_axis_tlast} = q0[0];
      s01_axis_tvalid = q1.size() > 0;
      if (q1.size() > 0) {s01_axis_tdata, s01_axis_tkeep, s01_axis_tuser, s01_axis_tlast} = q1[0];
    end
  end

  // Reference model: frame ownership, buffer occupancy (at most two beats) and
  // an in-order queue of beats owed downstream.
  initial begin
    bit    in_frame, cur_sel, armed, g_valid, g_sel, exp_rdy, v;
    beat_t b;
    in_frame = 0; cur_sel = 0; armed = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        check("rst_m_tvalid", m_axis_tvalid, 0);
        check("rst_m_tdata", m_axis_tdata, 0);
        check("rst_m_tkeep", m_axis_tkeep, 0);
        check("rst_m_tlast", m_axis_tlast, 0);
        check("rst_m_tuser", m_axis_tuser, 0);
        check("rst_s00_tready", s00_axis_tready, 0);
        check("rst_s01_tready", s01_axis_tready, 0);
        exp_q.delete();
        in_frame = 0; cur_sel = 0; armed = 0;
      end else begin
        g_valid = in_frame || enable;
        g_sel   = in_frame ? cur_sel : select;
        exp_rdy = armed && (exp_q.size() < 2);
        check("s00_tready", s00_axis_tready, g_valid && !g_sel && exp_rdy);
        check("s01_tready", s01_axis_tready, g_valid && g_sel && exp_rdy);
        check("m_tvalid", m_axis_tvalid, exp_q.size() > 0);
        if (m_axis_tvalid && m_axis_tready) begin
          log_data.push_back(m_axis_tdata);
          log_last.push_back(m_axis_tlast);
          log_cyc.push_back(cyc);
          $display("[TB] out beat cyc=%0d data=%08h keep=%h user=%0d last=%0d",
                   cyc, m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast);
        end
        if (exp_q.size() > 0) begin
          check("m_tdata", m_axis_tdata, exp_q[0].data);
          check("m_tkeep", m_axis_tkeep, exp_q[0].keep);
          check("m_tuser", m_axis_tuser, exp_q[0].user);
          check("m_tlast", m_axis_tlast, exp_q[0].last);
          check("m_tid", m_axis_tid, 0);
          check("m_tdest", m_axis_tdest, 0);
          if (m_axis_tready) void'(exp_q.pop_front());
        end
        v = g_sel ? s01_axis_tvalid : s00_axis_tvalid;
        if (g_valid && v && exp_rdy) begin
          b = g_sel ? mk(s01_axis_tdata, s01_axis_tkeep, s01_axis_tuser[0], s01_axis_tlast)
                    : mk(s00_axis_tdata, s00_axis_tkeep, s00_axis_tuser[0], s00_axis_tlast);
          exp_q.push_back(b);
          cur_sel  = g_sel;
          in_frame = !b.last;
        end
        armed = 1;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, a0, base2;
    logic [3:0] pat;

    // 1: reset held with both ports valid, then first beat passes
    #1 rst_n = 1'b0;
    enable = 1'b1; select = 1'b0; m_axis_tready = 1'b1;
    push_frame(0, 32'hF0, 1);
    push_frame(1, 32'hF1, 1);
    step(5);
    rst_n = 1'b1;
    wait_log(1, 10);
    check("t1_first_data", log_data[0], 32'hF0);
    check("t1_first_last", log_last[0], 1);
    select = 1'b1;
    wait_log(2, 10);
    check("t1_second_data", log_data[1], 32'hF1);

    // 2: select flips mid-frame, s00 frame completes before s01 is served
    base = log_data.size();
    a0 = acc0;
    select = 1'b0;
    push_frame(0, 32'hA0, 4);
    push_frame(1, 32'hB0, 2);
    wait_accept(0, a0 + 2, 20);
    select = 1'b1;
    wait_log(base + 6, 40);
    for (int i = 0; i < 4; i++) begin
      check("t2_a_data", log_data[base + i], 32'hA0 + 32'(i));
      check("t2_a_last", log_last[base + i], i == 3);
    end
    check("t2_b_first", log_data[base + 4], 32'hB0);

    // 3: downstream stalls in a 1,0,0,1 pattern during an 8-beat s01 frame
    base = log_data.size();
    push_frame(1, 32'hC0, 8);
    pat = 4'b1001;
    for (int i = 0; i < 24; i++) begin
      m_axis_tready = pat[i % 4];
      step(1);
    end
    m_axis_tready = 1'b1;
    wait_log(base + 8, 20);
    for (int i = 0; i < 8; i++) begin
      check("t3_order", log_data[base + i], 32'hC0 + 32'(i));
    end
    check("t3_count", log_data.size(), base + 8);

    // 4: single-beat frames alternating ports on consecutive clocks
    base = log_data.size();
    q0.push_back(mk(32'h11, 4'hF, 1'b0, 1'b1));
    q1.push_back(mk(32'h22, 4'hF, 1'b1, 1'b1));
    q0.push_back(mk(32'h33, 4'hF, 1'b0, 1'b1));
    select = 1'b0;
    step(1);
    select = 1'b1;
    step(1);
    select = 1'b0;
    wait_log(base + 3, 10);
    check("t4_d0", log_data[base], 32'h11);
    check("t4_d1", log_data[base + 1], 32'h22);
    check("t4_d2", log_data[base + 2], 32'h33);
    check("t4_gap1", log_cyc[base + 1] - log_cyc[base], 1);
    check("t4_gap2", log_cyc[base + 2] - log_cyc[base + 1], 1);
    check("t4_lasts", {log_last[base], log_last[base + 1], log_last[base + 2]}, 3'b111);

    // 5: enable low blocks new frames; dropping it mid-frame lets the frame finish
    base = log_data.size();
    enable = 1'b0;
    push_frame(0, 32'hD0, 5);
    push_frame(1, 32'hE0, 3);
    step(10);
    check("t5_hold_log", log_data.size(), base);
    a0 = acc0;
    enable = 1'b1;
    select = 1'b0;
    wait_accept(0, a0 + 2, 10);
    enable = 1'b0;
    wait_log(base + 5, 30);
    step(10);
    check("t5_frame_only", log_data.size(), base + 5);
    check("t5_first", log_data[base], 32'hD0);
    check("t5_last", log_data[base + 4], 32'hD4);
    check("t5_last_flag", log_last[base + 4], 1);
    enable = 1'b1;
    select = 1'b1;
    wait_log(base + 8, 30);
    check("t5_e_first", log_data[base + 5], 32'hE0);

    // 6: reset in the middle of a 6-beat frame, then a clean frame
    select = 1'b0;
    a0 = acc0;
    push_frame(0, 32'h60, 6);
    wait_accept(0, a0 + 3, 20);
    rst_n = 1'b0;
    q0.delete();
    q1.delete();
    #1;
    check("t6_async_clear", m_axis_tvalid, 0);
    step(1);
    push_frame(0, 32'h70, 3);
    step(3);
    rst_n = 1'b1;
    base2 = log_data.size();
    wait_log(base2 + 3, 20);
    check("t6_after0", log_data[base2], 32'h70);
    check("t6_after2", log_data[base2 + 2], 32'h72);
    check("t6_after_last", log_last[base2 + 2], 1);

    step(5);
    check("end_q0_empty", q0.size(), 0);
    check("end_q1_empty", q1.size(), 0);
    check("end_model_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
